// File: rtl/rx_stream_packer.sv
// Receive-stream packer: buffers 24-bit IQ words in a FIFO and serialises each
// word MSB-first into OW-bit beats for the Raspberry Pi sample bus.
module rx_stream_packer #(
  parameter int DW     = 24,
  parameter int OW     = 4,
  parameter int DEPTH  = 1024,
  parameter int HI_THR = 256,
  parameter int LO_THR = 128,
  parameter int DROP   = 0
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [DW-1:0]            s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  input  logic [1:0]               s_tuser,
  input  logic                     rd_stb,
  input  logic                     flush,
  input  logic                     clr_stat,
  output logic [OW-1:0]            out_data,
  output logic                     out_last,
  output logic [1:0]               out_user,
  output logic                     samples_avail,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              ovf_cnt,
  output logic                     underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = DW / OW;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int EW = DW + 3;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   HI_LVL    = (AW + 1)'(HI_THR);
  localparam logic [AW:0]   LO_LVL    = (AW + 1)'(LO_THR);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic          run;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] word_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [0:0]    state;
  logic [BW-1:0] beat;
  logic [DW-1:0] shifted;
  logic          full;
  logic          empty;
  logic          last_beat;
  logic          pop;
  logic          push;
  logic          drop_evt;

  // Reset release is retimed so writes start on the second edge after rstb rises.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) run <= 1'b0;
    else       run <= 1'b1;
  end

  assign full      = (count == FULL_LVL);
  assign empty     = (count == '0);
  assign last_beat = (beat == LAST_BEAT);
  assign level     = count;

  generate
    if (DROP != 0) begin : g_drop
      assign s_tready = 1'b1;
    end else begin : g_backpressure
      assign s_tready = !rstb || (run && !full);
    end
  endgenerate

  // Pop either refills an idle serialiser or prefetches on the final beat strobe.
  assign pop      = !flush && !empty &&
                    ((state == S_IDLE) || (rd_stb && last_beat));
  assign push     = run && !flush && s_tvalid && s_tready && (!full || pop);
  assign drop_evt = (DROP != 0) && run && !flush && s_tvalid && full && !pop;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // The RAM output register doubles as the serialiser word.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_tlast, s_tuser, s_tdata};
    if (pop)  word_q      <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= S_IDLE;
      beat  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      beat  <= '0;
    end else if (pop) begin
      state <= S_SHIFT;
      beat  <= '0;
    end else if ((state == S_SHIFT) && rd_stb) begin
      if (last_beat) state <= S_IDLE;
      else           beat  <= beat + 1'b1;
    end
  end

  assign shifted = word_q[DW-1:0] << (OW * beat);

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    out_user = '0;
    if (state == S_SHIFT) begin
      out_data = shifted[DW-1 -: OW];
      out_last = word_q[DW+2] && last_beat;
      out_user = word_q[DW +: 2];
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ovf_cnt  <= '0;
      underrun <= 1'b0;
    end else begin
      if (clr_stat)                            ovf_cnt <= '0;
      else if (drop_evt && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
      if (clr_stat)                            underrun <= 1'b0;
      else if (rd_stb && state == S_IDLE)      underrun <= 1'b1;
    end
  end

  // Hysteresis: between the thresholds the flag keeps its previous value.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                samples_avail <= 1'b0;
    else if (flush)           samples_avail <= 1'b0;
    else if (count >= HI_LVL) samples_avail <= 1'b1;
    else if (count < LO_LVL)  samples_avail <= 1'b0;
  end

endmodule

// File: tb/tb_rx_stream_packer.sv
// Scoreboard bench for rx_stream_packer: a default instance plus two DEPTH=16
// instances for backpressure and drop-policy behaviour.
module tb_rx_stream_packer;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct packed {
    logic       last;
    logic [1:0] user;
    logic [3:0] data;
  } beat_t;
  beat_t exp_q[$];

  // Instance A: default parameters
  logic [23:0] s_tdata_a;
  logic        s_tvalid_a, s_tlast_a, rd_stb_a, flush_a, clr_stat_a;
  logic [1:0]  s_tuser_a;
  logic        s_tready_a, out_last_a, samples_avail_a, underrun_a;
  logic [3:0]  out_data_a;
  logic [1:0]  out_user_a;
  logic [10:0] level_a;
  logic [15:0] ovf_cnt_a;

  // Instance B: DEPTH=16, backpressure
  logic [23:0] s_tdata_b;
  logic        s_tvalid_b, rd_stb_b, flush_b, clr_stat_b;
  logic        s_tready_b, out_last_b, samples_avail_b, underrun_b;
  logic [3:0]  out_data_b;
  logic [1:0]  out_user_b;
  logic [4:0]  level_b;
  logic [15:0] ovf_cnt_b;

  // Instance C: DEPTH=16, drop when full
  logic [23:0] s_tdata_c;
  logic        s_tvalid_c, rd_stb_c, flush_c, clr_stat_c;
  logic        s_tready_c, out_last_c, samples_avail_c, underrun_c;
  logic [3:0]  out_data_c;
  logic [1:0]  out_user_c;
  logic [4:0]  level_c;
  logic [15:0] ovf_cnt_c;

  rx_stream_packer dut_a (
    .clk(clk), .rstb(rstb), .s_tdata(s_tdata_a), .s_tvalid(s_tvalid_a),
    .s_tready(s_tready_a), .s_tlast(s_tlast_a), .s_tuser(s_tuser_a),
    .rd_stb(rd_stb_a), .flush(flush_a), .clr_stat(clr_stat_a),
    .out_data(out_data_a), .out_last(out_last_a), .out_user(out_user_a),
    .samples_avail(samples_avail_a), .level(level_a), .ovf_cnt(ovf_cnt_a),
    .underrun(underrun_a)
  );

  rx_stream_packer #(.DEPTH(16), .HI_THR(8), .LO_THR(4), .DROP(0)) dut_b (
    .clk(clk), .rstb(rstb), .s_tdata(s_tdata_b), .s_tvalid(s_tvalid_b),
    .s_tready(s_tready_b), .s_tlast(1'b0), .s_tuser(2'd0),
    .rd_stb(rd_stb_b), .flush(flush_b), .clr_stat(clr_stat_b),
    .out_data(out_data_b), .out_last(out_last_b), .out_user(out_user_b),
    .samples_avail(samples_avail_b), .level(level_b), .ovf_cnt(ovf_cnt_b),
    .underrun(underrun_b)
  );

  rx_stream_packer #(.DEPTH(16), .HI_THR(8), .LO_THR(4), .DROP(1)) dut_c (
    .clk(clk), .rstb(rstb), .s_tdata(s_tdata_c), .s_tvalid(s_tvalid_c),
    .s_tready(s_tready_c), .s_tlast(1'b0), .s_tuser(2'd1),
    .rd_stb(rd_stb_c), .flush(flush_c), .clr_stat(clr_stat_c),
    .out_data(out_data_c), .out_last(out_last_c), .out_user(out_user_c),
    .samples_avail(samples_avail_c), .level(level_c), .ovf_cnt(ovf_cnt_c),
    .underrun(underrun_c)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Drive one word into A for one cycle and queue its six expected beats.
  task automatic applyStimulus(input logic [23:0] data, input logic last, input logic [1:0] user);
    beat_t e;
    s_tdata_a  = data;
    s_tlast_a  = last;
    s_tuser_a  = user;
    s_tvalid_a = 1'b1;
    checkOutput("tready_a", s_tready_a, 1);
    for (int b = 0; b < 6; b++) begin
      e.last = last && (b == 5);
      e.user = user;
      e.data = data[23 - 4*b -: 4];
      exp_q.push_back(e);
    end
    @(negedge clk);
    s_tvalid_a = 1'b0;
    s_tlast_a  = 1'b0;
  endtask

  task automatic readBeat();
    beat_t e;
    checkOutput("sb_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    checkOutput("out_data", out_data_a, e.data);
    checkOutput("out_last", out_last_a, e.last);
    checkOutput("out_user", out_user_a, e.user);
    rd_stb_a = 1'b1;
    @(negedge clk);
    rd_stb_a = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic avail_at_128;
    rstb = 1'b0;
    {s_tdata_a, s_tvalid_a, s_tlast_a, s_tuser_a, rd_stb_a, flush_a, clr_stat_a} = '0;
    {s_tdata_b, s_tvalid_b, rd_stb_b, flush_b, clr_stat_b} = '0;
    {s_tdata_c, s_tvalid_c, rd_stb_c, flush_c, clr_stat_c} = '0;

    #12;
    checkOutput("rst_out_data", out_data_a, 0);
    checkOutput("rst_out_last", out_last_a, 0);
    checkOutput("rst_out_user", out_user_a, 0);
    checkOutput("rst_level", level_a, 0);
    checkOutput("rst_avail", samples_avail_a, 0);
    checkOutput("rst_ovf", ovf_cnt_a, 0);
    checkOutput("rst_underrun", underrun_a, 0);
    checkOutput("rst_tready", s_tready_a, 1);

    // First edge after release only arms the packer; the word lands on the second.
    @(negedge clk);
    rstb = 1'b1;
    s_tdata_a  = 24'hABCDEF;
    s_tvalid_a = 1'b1;
    @(negedge clk);
    checkOutput("no_write_first_edge", level_a, 0);
    applyStimulus(24'hABCDEF, 1'b0, 2'd0);
    checkOutput("level_after_push", level_a, 1);
    checkOutput("latency_not_yet", out_data_a, 0);
    applyStimulus(24'h123456, 1'b0, 2'd0);
    checkOutput("latency_two", out_data_a, 4'hA);
    applyStimulus(24'h789ABC, 1'b0, 2'd0);
    checkOutput("level_two_queued", level_a, 2);
    repeat (18) readBeat();
    checkOutput("idle_out_data", out_data_a, 0);
    checkOutput("idle_level", level_a, 0);
    checkOutput("underrun_before", underrun_a, 0);
    rd_stb_a = 1'b1;
    @(negedge clk);
    rd_stb_a = 1'b0;
    checkOutput("underrun_set", underrun_a, 1);
    clr_stat_a = 1'b1;
    @(negedge clk);
    clr_stat_a = 1'b0;
    checkOutput("underrun_clr", underrun_a, 0);

    applyStimulus(24'h2468AC, 1'b1, 2'd2);
    @(negedge clk);
    repeat (6) readBeat();
    checkOutput("tlast_after", out_last_a, 0);

    // The serialiser absorbs the first word, so one extra word is offered.
    s_tvalid_a = 1'b1;
    n = 0;
    while (level_a != 256 && n < 400) begin
      s_tdata_a = 24'(n);
      @(negedge clk);
      n++;
    end
    s_tvalid_a = 1'b0;
    checkOutput("fill_level", level_a, 256);
    checkOutput("avail_lag_256", samples_avail_a, 0);
    @(negedge clk);
    checkOutput("avail_set_256", samples_avail_a, 1);

    rd_stb_a = 1'b1;
    avail_at_128 = 1'b0;
    n = 0;
    while (level_a != 127 && n < 1200) begin
      @(negedge clk);
      n++;
      if (level_a == 128) avail_at_128 = samples_avail_a;
    end
    rd_stb_a = 1'b0;
    checkOutput("drain_level", level_a, 127);
    checkOutput("avail_hold_128", avail_at_128, 1);
    checkOutput("avail_lag_127", samples_avail_a, 1);
    @(negedge clk);
    checkOutput("avail_clear_127", samples_avail_a, 0);

    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
    checkOutput("a_flush_level", level_a, 0);
    checkOutput("a_flush_data", out_data_a, 0);

    // Drop policy at DEPTH=16: 21 offers, 17 held (16 + serialiser), 4 dropped.
    s_tvalid_c = 1'b1;
    for (int i = 0; i < 21; i++) begin
      s_tdata_c = 24'hCCCCC0 + 24'(i);
      @(negedge clk);
    end
    s_tvalid_c = 1'b0;
    checkOutput("c_level_full", level_c, 16);
    checkOutput("c_ovf_4", ovf_cnt_c, 4);
    checkOutput("c_avail", samples_avail_c, 1);
    checkOutput("c_tready_tied", s_tready_c, 1);
    s_tvalid_c = 1'b1;
    clr_stat_c = 1'b1;
    @(negedge clk);
    clr_stat_c = 1'b0;
    checkOutput("c_clr_wins", ovf_cnt_c, 0);
    @(negedge clk);
    s_tvalid_c = 1'b0;
    checkOutput("c_ovf_1", ovf_cnt_c, 1);
    rd_stb_c = 1'b1;
    repeat (5) @(negedge clk);
    s_tvalid_c = 1'b1;
    s_tdata_c  = 24'hC0FFEE;
    @(negedge clk);
    s_tvalid_c = 1'b0;
    checkOutput("c_full_pop_store", level_c, 16);
    checkOutput("c_full_pop_no_ovf", ovf_cnt_c, 1);
    repeat (2) @(negedge clk);
    rd_stb_c = 1'b0;
    checkOutput("c_mid_word", out_data_c, 4'hC);
    flush_c    = 1'b1;
    s_tvalid_c = 1'b1;
    @(negedge clk);
    flush_c    = 1'b0;
    s_tvalid_c = 1'b0;
    checkOutput("c_flush_data", out_data_c, 0);
    checkOutput("c_flush_level", level_c, 0);
    checkOutput("c_flush_avail", samples_avail_c, 0);
    checkOutput("c_flush_ovf_kept", ovf_cnt_c, 1);

    // Backpressure at DEPTH=16
    s_tvalid_b = 1'b1;
    s_tdata_b  = 24'hB5B5B5;
    n = 0;
    while (level_b != 16 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b_level_full", level_b, 16);
    checkOutput("b_tready_low", s_tready_b, 0);
    rd_stb_b = 1'b1;
    repeat (6) @(negedge clk);
    rd_stb_b = 1'b0;
    checkOutput("b_reopen_tready", s_tready_b, 1);
    checkOutput("b_reopen_level", level_b, 15);
    @(negedge clk);
    s_tvalid_b = 1'b0;
    checkOutput("b_refill_level", level_b, 16);
    checkOutput("b_ovf_zero", ovf_cnt_b, 0);

    rd_stb_b = 1'b1;
    repeat (2) @(negedge clk);
    rd_stb_b = 1'b0;
    checkOutput("b_pre_reset_data", out_data_b, 4'hB);
    checkOutput("b_pre_reset_avail", samples_avail_b, 1);
    #2 rstb = 1'b0;
    #1;
    checkOutput("b_async_data", out_data_b, 0);
    checkOutput("b_async_level", level_b, 0);
    checkOutput("b_async_avail", samples_avail_b, 0);
    checkOutput("b_async_tready", s_tready_b, 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
